mpmc11_resv_initiator: RTL and testbench

// - Channel-side initiator for the mpmc11 address-reservation (LR/SC) protocol; one instance per channel.
// - Takes CPU load-reserved / store-conditional requests and drives the reservation request (sr/adr) to the controller's reservation manager.
// - At SC time, checks the manager's bucket table and either issues the conditional write (we+cr) or reports failure.

---
 rtl/mpmc11_pkg.sv | 19 +
 rtl/mpmc11_resv_match.sv | 35 +++
 rtl/mpmc11_resv_initiator.sv | 212 +++++++++++++++++++++
 tb/tb_mpmc11_resv_initiator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types and constants for the mpmc11 reservation (LR/SC) logic.
package mpmc11_pkg;

    localparam int unsigned MPMC11_ADR_W          = 32;
    localparam int unsigned MPMC11_RESV_GRAN_LSB  = 4;
    localparam int unsigned MPMC11_RESV_TAG_W     = MPMC11_ADR_W - MPMC11_RESV_GRAN_LSB;
    localparam int unsigned MPMC11_RESV_CH_W      = 4;
    localparam int unsigned MPMC11_RESV_CNT_W     = 20;
    localparam logic [3:0]  MPMC11_RESV_NONE      = 4'hF;

    typedef enum logic [2:0] {
        RESV_IDLE   = 3'd0,
        RESV_LR_REQ = 3'd1,
        RESV_SC_CHK = 3'd2,
        RESV_SC_WR  = 3'd3,
        RESV_DONE   = 3'd4
    } mpmc11_resv_init_state_t;

endpackage

// File: rtl/mpmc11_resv_match.sv
// mpmc11_resv_match: NAR-way compare of (CHANNEL, address granule) against the manager's bucket table.
module mpmc11_resv_match
    import mpmc11_pkg::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned NAR     = 2
) (
    input  logic [MPMC11_RESV_CH_W*NAR-1:0] i_resv_ch,
    input  logic [MPMC11_ADR_W*NAR-1:0]     i_resv_adr,
    input  logic [MPMC11_RESV_TAG_W-1:0]    i_tag,
    output logic                            o_held_c
);

    localparam int unsigned CH_W  = MPMC11_RESV_CH_W;
    localparam int unsigned ADR_W = MPMC11_ADR_W;
    localparam int unsigned GRAN  = MPMC11_RESV_GRAN_LSB;
    localparam int unsigned TAG_W = MPMC11_RESV_TAG_W;

    // Offsets below the reservation granule never take part in the compare.
    logic w_unused_lsb;

    always_comb begin
        o_held_c     = 1'b0;
        w_unused_lsb = 1'b0;
        for (int n = 0; n < int'(NAR); n++) begin
            w_unused_lsb = w_unused_lsb ^ (^i_resv_adr[n*ADR_W +: GRAN]);
            if ((i_resv_ch[n*CH_W +: CH_W] != MPMC11_RESV_NONE) &&
                (i_resv_ch[n*CH_W +: CH_W] == CH_W'(CHANNEL)) &&
                (i_resv_adr[n*ADR_W + GRAN +: TAG_W] == i_tag)) begin
                o_held_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpmc11_resv_initiator.sv
// mpmc11_resv_initiator: per-channel LR/SC initiator towards the reservation manager and controller.
// Optional local reservation lifetime counter: define MPMC11_RESV_TIMEOUT_EN.
module mpmc11_resv_initiator
    import mpmc11_pkg::*;
#(
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned NAR     = 2,
    parameter logic [19:0] TIMEOUT = 20'hFFFFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cs_i,
    input  logic                            lr_i,
    input  logic                            sc_i,
    input  logic [31:0]                     adr_i,
    output logic                            busy_o,
    output logic                            ack_o,
    output logic                            sc_ok_o,
    output logic                            sr_o,
    output logic [31:0]                     radr_o,
    input  logic                            rack_i,
    input  logic [MPMC11_RESV_CH_W*NAR-1:0] resv_ch_i,
    input  logic [MPMC11_ADR_W*NAR-1:0]     resv_adr_i,
    output logic                            we_o,
    output logic                            cr_o,
    output logic [31:0]                     wadr_o,
    input  logic                            wack_i
);

    localparam int unsigned ADR_W = MPMC11_ADR_W;
    localparam int unsigned GRAN  = MPMC11_RESV_GRAN_LSB;
    localparam int unsigned TAG_W = MPMC11_RESV_TAG_W;

    localparam logic [2:0] ST_IDLE   = 3'(RESV_IDLE);
    localparam logic [2:0] ST_LR_REQ = 3'(RESV_LR_REQ);
    localparam logic [2:0] ST_SC_CHK = 3'(RESV_SC_CHK);
    localparam logic [2:0] ST_SC_WR  = 3'(RESV_SC_WR);
    localparam logic [2:0] ST_DONE   = 3'(RESV_DONE);

    if (CHANNEL > 7 || NAR == 0 || TIMEOUT == 20'd0) begin : g_cfg_chk
        $error("mpmc11_resv_initiator: illegal CHANNEL/NAR/TIMEOUT");
    end

    logic [2:0]       r_state;
    logic [ADR_W-1:0] r_adr;
    logic [ADR_W-1:0] r_radr;
    logic [ADR_W-1:0] r_wadr;
    logic             r_sr;
    logic             r_we;
    logic             r_ack;
    logic             r_sc_ok;
    logic             r_busy;
    logic             r_lres_v;
    logic [TAG_W-1:0] r_lres_tag;

    logic [2:0]       w_state_nxt;
    logic [ADR_W-1:0] w_adr_nxt;
    logic [ADR_W-1:0] w_radr_nxt;
    logic [ADR_W-1:0] w_wadr_nxt;
    logic             w_sr_nxt;
    logic             w_we_nxt;
    logic             w_ack_nxt;
    logic             w_sc_ok_nxt;
    logic             w_lres_set;
    logic             w_lres_clr;
    logic             w_held;
    logic             w_commit;
    logic             w_tmo;

    mpmc11_resv_match #(
        .CHANNEL (CHANNEL),
        .NAR     (NAR)
    ) u_match (
        .i_resv_ch  (resv_ch_i),
        .i_resv_adr (resv_adr_i),
        .i_tag      (r_adr[ADR_W-1:GRAN]),
        .o_held_c   (w_held)
    );

    // SC commits only if the manager still holds our bucket and our local reservation covers the granule.
    assign w_commit = w_held && r_lres_v && (r_lres_tag == r_adr[ADR_W-1:GRAN]);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_radr_nxt  = r_radr;
        w_wadr_nxt  = r_wadr;
        w_sr_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_ack_nxt   = 1'b0;
        w_sc_ok_nxt = 1'b0;
        w_lres_set  = 1'b0;
        w_lres_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cs_i && lr_i) begin
                    w_state_nxt = ST_LR_REQ;
                    w_adr_nxt   = adr_i;
                    w_radr_nxt  = adr_i;
                    w_sr_nxt    = 1'b1;
                end else if (cs_i && sc_i) begin
                    w_state_nxt = ST_SC_CHK;
                    w_adr_nxt   = adr_i;
                end
            end
            ST_LR_REQ: begin
                if (rack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_ack_nxt   = 1'b1;
                    w_lres_set  = 1'b1;
                end else begin
                    w_sr_nxt    = 1'b1;
                end
            end
            ST_SC_CHK: begin
                if (w_commit) begin
                    w_state_nxt = ST_SC_WR;
                    w_we_nxt    = 1'b1;
                    w_wadr_nxt  = r_adr;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = 1'b1;
                    w_lres_clr  = 1'b1;
                end
            end
            ST_SC_WR: begin
                if (wack_i) begin
                    w_state_nxt = ST_IDLE;
                    w_ack_nxt   = 1'b1;
                    w_sc_ok_nxt = 1'b1;
                    w_lres_clr  = 1'b1;
                end else begin
                    w_we_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_radr  <= '0;
            r_wadr  <= '0;
            r_sr    <= 1'b0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_sc_ok <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_radr  <= w_radr_nxt;
            r_wadr  <= w_wadr_nxt;
            r_sr    <= w_sr_nxt;
            r_we    <= w_we_nxt;
            r_ack   <= w_ack_nxt;
            r_sc_ok <= w_sc_ok_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

`ifdef MPMC11_RESV_TIMEOUT_EN
    logic [MPMC11_RESV_CNT_W-1:0] r_tcnt;

    // Lifetime counter restarts on every LR grant and saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_lres_set) begin
            r_tcnt <= '0;
        end else if (r_lres_v && (r_tcnt != '1)) begin
            r_tcnt <= r_tcnt + MPMC11_RESV_CNT_W'(1);
        end
    end

    assign w_tmo = r_lres_v && (r_tcnt >= TIMEOUT);
`else
    assign w_tmo = 1'b0;
`endif

    // Local reservation; a new LR simply overwrites the recorded granule.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lres_v   <= 1'b0;
            r_lres_tag <= '0;
        end else if (w_lres_set) begin
            r_lres_v   <= 1'b1;
            r_lres_tag <= r_adr[ADR_W-1:GRAN];
        end else if (w_lres_clr || w_tmo) begin
            r_lres_v   <= 1'b0;
        end
    end

    assign busy_o  = r_busy;
    assign ack_o   = r_ack;
    assign sc_ok_o = r_sc_ok;
    assign sr_o    = r_sr;
    assign radr_o  = r_radr;
    assign we_o    = r_we;
    assign cr_o    = r_we;
    assign wadr_o  = r_wadr;

endmodule

// File: tb/tb_mpmc11_resv_initiator.sv
// tb_mpmc11_resv_initiator: vector table, directed corner sequences and randomized LR/SC traffic vs a reference model.
module tb_mpmc11_resv_initiator;

    localparam int unsigned CH  = 5;
    localparam int unsigned NAR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_i, lr_i, sc_i;
    logic [31:0] adr_i;
    logic        busy_o, ack_o, sc_ok_o, sr_o, we_o, cr_o;
    logic [31:0] radr_o, wadr_o;
    logic        rack_i, wack_i;
    logic [3:0]  bch0, bch1;
    logic [31:0] badr0, badr1;
    logic [4*NAR-1:0]  resv_ch_i;
    logic [32*NAR-1:0] resv_adr_i;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_v;
    logic [31:0] m_adr;

    assign resv_ch_i  = {bch1, bch0};
    assign resv_adr_i = {badr1, badr0};

    always #5 clk = ~clk;

    mpmc11_resv_initiator #(.CHANNEL(CH), .NAR(NAR), .TIMEOUT(20'd16)) dut (
        .clk(clk), .rst(rst), .cs_i(cs_i), .lr_i(lr_i), .sc_i(sc_i), .adr_i(adr_i),
        .busy_o(busy_o), .ack_o(ack_o), .sc_ok_o(sc_ok_o), .sr_o(sr_o), .radr_o(radr_o),
        .rack_i(rack_i), .resv_ch_i(resv_ch_i), .resv_adr_i(resv_adr_i),
        .we_o(we_o), .cr_o(cr_o), .wadr_o(wadr_o), .wack_i(wack_i)
    );

    typedef struct {
        bit cs; bit lr; bit sc; logic [31:0] adr;
        logic [3:0] ch0; logic [31:0] b0; logic [3:0] ch1; logic [31:0] b1;
        int rack_dly; int wack_dly;
        bit exp_ack; bit exp_ok; int exp_lat; int exp_sr; int exp_we;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request from IDLE; plays the manager (rack) and controller (wack) and checks the outcome.
    task automatic txn(input string name, input bit cs, input bit lr, input bit sc, input logic [31:0] adr,
                       input int rack_dly, input int wack_dly, input bit exp_ack, input bit exp_ok,
                       input int exp_lat, input int exp_sr, input int exp_we);
        bit got_ack = 1'b0;
        bit got_ok  = 1'b0;
        int lat = 0, srn = 0, wen = 0, badn = 0, busyn = 0;
        int limit = exp_ack ? 64 : 6;
        cs_i = cs; lr_i = lr; sc_i = sc; adr_i = adr; rack_i = 1'b1; wack_i = 1'b0;
        for (int cyc = 1; cyc <= limit && !got_ack; cyc++) begin
            step();
            cs_i = 1'b0; lr_i = 1'b0; sc_i = 1'b0; adr_i = 32'hDEAD_BEEF;
            if (busy_o) busyn++;
            if (sr_o) begin
                srn++;
                if (radr_o !== adr) badn++;
                rack_i = ((srn - 1) == rack_dly);
            end else begin
                rack_i = 1'b1;
            end
            if (we_o) begin
                wen++;
                if (wadr_o !== adr || cr_o !== 1'b1) badn++;
                wack_i = ((wen - 1) == wack_dly);
            end else begin
                wack_i = 1'b0;
                if (cr_o !== 1'b0) badn++;
            end
            if (ack_o) begin
                got_ack = 1'b1;
                lat     = cyc;
                got_ok  = sc_ok_o;
            end
        end
        chk({name, ".ack"}, 32'(got_ack), 32'(exp_ack));
        chk({name, ".sr_cycles"}, 32'(srn), 32'(exp_sr));
        chk({name, ".we_cycles"}, 32'(wen), 32'(exp_we));
        chk({name, ".addr"}, 32'(badn), 32'd0);
        if (exp_ack) begin
            chk({name, ".sc_ok"}, 32'(got_ok), 32'(exp_ok));
            chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
            step();
            chk({name, ".after"}, 32'({ack_o, busy_o, sr_o, we_o}), 32'd0);
        end else begin
            chk({name, ".busy"}, 32'(busyn), 32'd0);
        end
    endtask

    function automatic bit model_held(input logic [31:0] a);
        return ((bch0 == 4'(CH)) && ((badr0 >> 4) == (a >> 4))) ||
               ((bch1 == 4'(CH)) && ((badr1 >> 4) == (a >> 4)));
    endfunction

    // Reference: LR grants a reservation; SC succeeds iff the bucket is held and the local one covers the granule.
    task automatic model_txn(input string name, input bit is_lr, input logic [31:0] adr,
                             input int rack_dly, input int wack_dly);
        bit ok;
        if (is_lr) begin
            txn(name, 1, 1, 0, adr, rack_dly, wack_dly, 1, 0, rack_dly + 2, rack_dly + 1, 0);
            m_v = 1'b1; m_adr = adr;
        end else begin
            ok = model_held(adr) && m_v && ((m_adr >> 4) == (adr >> 4));
            if (ok) txn(name, 1, 0, 1, adr, rack_dly, wack_dly, 1, 1, wack_dly + 3, 0, wack_dly + 1);
            else    txn(name, 1, 0, 1, adr, rack_dly, wack_dly, 1, 0, 2, 0, 0);
            m_v = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t vt[21];
        logic [31:0] pool[6];
        logic [3:0]  chs[3];
        logic [31:0] a;

        vt[0]  = '{1,1,0,32'h1000,      4'hF,32'h0,         4'hF,32'h0,    1,0, 1,0,3,2,0};
        vt[1]  = '{1,0,1,32'h1008,      4'd5,32'h1000,      4'hF,32'h0,    0,1, 1,1,4,0,2};
        vt[2]  = '{1,0,1,32'h1000,      4'd3,32'h1000,      4'hF,32'h0,    0,0, 1,0,2,0,0};
        vt[3]  = '{1,1,0,32'h2000,      4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[4]  = '{1,0,1,32'h2004,      4'd3,32'h2000,      4'd5,32'h200C, 0,0, 1,1,3,0,1};
        vt[5]  = '{1,0,1,32'h2004,      4'd3,32'h2000,      4'd5,32'h200C, 0,0, 1,0,2,0,0};
        vt[6]  = '{1,1,0,32'h3000,      4'hF,32'h0,         4'hF,32'h0,    2,0, 1,0,4,3,0};
        vt[7]  = '{1,1,0,32'h4010,      4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[8]  = '{1,0,1,32'h3000,      4'd5,32'h3000,      4'hF,32'h0,    0,0, 1,0,2,0,0};
        vt[9]  = '{1,1,0,32'h5000,      4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[10] = '{1,0,1,32'h5010,      4'd5,32'h5000,      4'hF,32'h0,    0,0, 1,0,2,0,0};
        vt[11] = '{1,0,1,32'h5000,      4'd5,32'h5000,      4'hF,32'h0,    0,0, 1,0,2,0,0};
        vt[12] = '{1,1,1,32'h6000,      4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[13] = '{1,0,1,32'h6000,      4'd3,32'h6000,      4'd5,32'h6000, 0,3, 1,1,6,0,4};
        vt[14] = '{1,0,0,32'h7000,      4'd5,32'h7000,      4'hF,32'h0,    0,0, 0,0,0,0,0};
        vt[15] = '{0,1,0,32'h7000,      4'd5,32'h7000,      4'hF,32'h0,    0,0, 0,0,0,0,0};
        vt[16] = '{0,0,1,32'h7000,      4'd5,32'h7000,      4'hF,32'h0,    0,0, 0,0,0,0,0};
        vt[17] = '{1,1,0,32'h7FFF_FFF0, 4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[18] = '{1,0,1,32'h7FFF_FFFC, 4'd5,32'h7FFF_FFF0, 4'hF,32'h0,    0,0, 1,1,3,0,1};
        vt[19] = '{1,1,0,32'h1000,      4'hF,32'h0,         4'hF,32'h0,    0,0, 1,0,2,1,0};
        vt[20] = '{1,0,1,32'h1010,      4'd5,32'h1010,      4'hF,32'h0,    0,0, 1,0,2,0,0};

        rst = 1'b1; cs_i = 1'b0; lr_i = 1'b0; sc_i = 1'b0; adr_i = '0;
        rack_i = 1'b1; wack_i = 1'b0;
        bch0 = 4'hF; bch1 = 4'hF; badr0 = '0; badr1 = '0;
        repeat (3) step();
        chk("reset.ctrl", 32'({busy_o, ack_o, sc_ok_o, sr_o, we_o, cr_o}), 32'd0);
        chk("reset.radr", radr_o, 32'd0);
        chk("reset.wadr", wadr_o, 32'd0);
        rst = 1'b0;
        repeat (4) step();
        chk("idle_rack_high", 32'({busy_o, ack_o, sr_o, we_o}), 32'd0);

        for (int i = 0; i < 21; i++) begin
            bch0 = vt[i].ch0; badr0 = vt[i].b0; bch1 = vt[i].ch1; badr1 = vt[i].b1;
            txn($sformatf("vec%0d", i), vt[i].cs, vt[i].lr, vt[i].sc, vt[i].adr,
                vt[i].rack_dly, vt[i].wack_dly, vt[i].exp_ack, vt[i].exp_ok,
                vt[i].exp_lat, vt[i].exp_sr, vt[i].exp_we);
        end
        m_v = 1'b0; m_adr = '0;

        pool = '{32'h1000, 32'h1008, 32'h1010, 32'h2000, 32'h200C, 32'h3FF0};
        chs  = '{4'(CH), 4'd3, 4'hF};
        for (int i = 0; i < 60; i++) begin
            bch0  = chs[$urandom_range(2)];  badr0 = pool[$urandom_range(5)];
            bch1  = chs[$urandom_range(2)];  badr1 = pool[$urandom_range(5)];
            a = pool[$urandom_range(5)];
            if ($urandom_range(1) == 1) begin bch0 = 4'(CH); badr0 = a; end
            model_txn($sformatf("rnd%0d", i), ($urandom_range(9) < 4), a,
                      int'($urandom_range(3)), int'($urandom_range(3)));
            repeat ($urandom_range(3)) step();
        end

        // Long gap between LR and SC: the reservation expires only when the lifetime counter is built in.
        bch0 = 4'(CH); badr0 = 32'h7000; bch1 = 4'hF;
        txn("tmo_lr", 1, 1, 0, 32'h7000, 0, 0, 1, 0, 2, 1, 0);
        repeat (20) step();
`ifdef MPMC11_RESV_TIMEOUT_EN
        txn("tmo_sc", 1, 0, 1, 32'h7000, 0, 0, 1, 0, 2, 0, 0);
`else
        txn("tmo_sc", 1, 0, 1, 32'h7000, 0, 0, 1, 1, 3, 0, 1);
`endif

        // Reset while the conditional write is outstanding.
        bch0 = 4'(CH); badr0 = 32'h8000;
        txn("rstwr_lr", 1, 1, 0, 32'h8000, 0, 0, 1, 0, 2, 1, 0);
        cs_i = 1'b1; sc_i = 1'b1; adr_i = 32'h8000; wack_i = 1'b0;
        step();
        cs_i = 1'b0; sc_i = 1'b0;
        step();
        chk("rstwr.we_before", 32'({we_o, cr_o, busy_o}), 32'h7);
        rst = 1'b1;
        step();
        chk("rstwr.in_reset", 32'({we_o, cr_o, busy_o, ack_o, sr_o}), 32'd0);
        rst = 1'b0;
        step();
        chk("rstwr.after", 32'({we_o, busy_o, ack_o}), 32'd0);
        txn("rstwr_sc", 1, 0, 1, 32'h8000, 0, 0, 1, 0, 2, 0, 0);

        // Reset while waiting for the manager's rack.
        cs_i = 1'b1; lr_i = 1'b1; adr_i = 32'h9000; rack_i = 1'b0;
        step();
        cs_i = 1'b0; lr_i = 1'b0;
        chk("rstlr.sr_before", 32'({sr_o, busy_o}), 32'h3);
        rst = 1'b1;
        step();
        rst = 1'b0; rack_i = 1'b1;
        chk("rstlr.in_reset", 32'({sr_o, busy_o, ack_o}), 32'd0);
        step();
        chk("rstlr.after", 32'({sr_o, busy_o, ack_o}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
